// File: rtl/alu_sweep_driver_if.sv
// ALU operand/result bus plus record stream for the ALU sweep driver.
// master: sweep driver (issues operands, emits records); slave: ALU + consumer.
interface alu_sweep_driver_if #(
  parameter int DATA_W = 8,
  parameter int OP_W   = 4
);
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [OP_W-1:0]   alu_opcode;
  logic [DATA_W-1:0] alu_result;
  logic              alu_cf;
  logic              alu_of;
  logic              alu_zf;
  logic              alu_nf;
  logic              rec_valid;
  logic              rec_ready;
  logic [DATA_W-1:0] rec_a;
  logic [DATA_W-1:0] rec_b;
  logic [OP_W-1:0]   rec_op;
  logic [DATA_W-1:0] rec_result;
  logic [3:0]        rec_flags;

  modport master (
    output alu_a, alu_b, alu_opcode,
    input  alu_result, alu_cf, alu_of, alu_zf, alu_nf,
    output rec_valid, rec_a, rec_b, rec_op, rec_result, rec_flags,
    input  rec_ready
  );

  modport slave (
    input  alu_a, alu_b, alu_opcode,
    output alu_result, alu_cf, alu_of, alu_zf, alu_nf,
    input  rec_valid, rec_a, rec_b, rec_op, rec_result, rec_flags,
    output rec_ready
  );
endinterface

// File: rtl/alu_sweep_driver.sv
// Sweeps op/a/b into an ALU, streams captured records, folds a signature.
// Ports: clk, rst_n, start, abort, busy, done, signature, vec_count, bus.
module alu_sweep_driver #(
  parameter int DATA_W        = 8,
  parameter int OP_W          = 4,
  parameter int A_MAX         = 127,
  parameter int B_MAX         = 127,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  output logic                busy,
  output logic                done,
  output logic [15:0]         signature,
  output logic [31:0]         vec_count,
  alu_sweep_driver_if.master  bus
);

  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [DATA_W-1:0] A_LAST  = DATA_W'(A_MAX);
  localparam logic [DATA_W-1:0] B_LAST  = DATA_W'(B_MAX);
  localparam logic [OP_W-1:0]   OP_LAST = '1;
  localparam logic [SW-1:0]     S_LAST  = SW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    HOLD,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [DATA_W-1:0] a_q, b_q;
  logic [OP_W-1:0]   op_q;
  logic [SW-1:0]     settle_q;
  logic              rv_q;
  logic [DATA_W-1:0] ra_q, rb_q, rres_q;
  logic [OP_W-1:0]   rop_q;
  logic [3:0]        rfl_q;
  logic [15:0]       sig_q;
  logic [31:0]       cnt_q;

  logic accept;
  logic last;
  logic settled;

  assign accept  = (state == HOLD) && rv_q && bus.rec_ready;
  assign last    = (op_q == OP_LAST) && (a_q == A_LAST)
                && (b_q == B_LAST);
  assign settled = (settle_q == S_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE, DONE: if (start) state_nx = DRIVE;
      DRIVE:      if (settled) state_nx = HOLD;
      HOLD:       if (accept) state_nx = last ? DONE : DRIVE;
      default:    state_nx = IDLE;
    endcase
    if (abort) state_nx = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      settle_q <= '0;
      rv_q     <= 1'b0;
      ra_q     <= '0;
      rb_q     <= '0;
      rop_q    <= '0;
      rres_q   <= '0;
      rfl_q    <= '0;
      sig_q    <= '0;
      cnt_q    <= '0;
    end else if (abort) begin
      rv_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            settle_q <= '0;
            sig_q    <= '0;
            cnt_q    <= '0;
          end
        end
        DRIVE: begin
          if (settled) begin
            ra_q   <= a_q;
            rb_q   <= b_q;
            rop_q  <= op_q;
            rres_q <= bus.alu_result;
            rfl_q  <= {bus.alu_cf, bus.alu_of,
                       bus.alu_zf, bus.alu_nf};
            rv_q   <= 1'b1;
          end else begin
            settle_q <= settle_q + 1'b1;
          end
        end
        HOLD: begin
          if (accept) begin
            sig_q    <= {sig_q[14:0], sig_q[15]}
                      ^ 16'({rfl_q, rres_q});
            cnt_q    <= cnt_q + 32'd1;
            rv_q     <= 1'b0;
            settle_q <= '0;
            // Final vector keeps operands so alu_* hold in DONE.
            if (!last) begin
              if (b_q == B_LAST) begin
                b_q <= '0;
                if (a_q == A_LAST) begin
                  a_q  <= '0;
                  op_q <= op_q + 1'b1;
                end else begin
                  a_q <= a_q + 1'b1;
                end
              end else begin
                b_q <= b_q + 1'b1;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.alu_a      = a_q;
  assign bus.alu_b      = b_q;
  assign bus.alu_opcode = op_q;
  assign bus.rec_valid  = rv_q;
  assign bus.rec_a      = ra_q;
  assign bus.rec_b      = rb_q;
  assign bus.rec_op     = rop_q;
  assign bus.rec_result = rres_q;
  assign bus.rec_flags  = rfl_q;

  assign busy      = (state == DRIVE) || (state == HOLD);
  assign done      = (state == DONE);
  assign signature = sig_q;
  assign vec_count = cnt_q;

endmodule
